// File: rtl/vr_vc_pkg.sv
// Shared types and helpers for valid/ready <-> valid/credit bridges.
package vr_vc_pkg;

  typedef enum logic {
    RESET  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bits needed to hold a credit count in the range 0..n inclusive.
  function automatic int credit_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vr_vc_credit_cnt.sv
// Saturating credit counter for credit-based transmitters (range 0..CREDIT_NUM).
// With VR_VC_CREDIT_CHECK_EN defined, overflow_o flags a return while already full.
module vr_vc_credit_cnt
  import vr_vc_pkg::*;
#(
  parameter int CREDIT_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dec_i,
  input  logic                             inc_i,
  output logic [credit_w(CREDIT_NUM)-1:0]  cnt_o,
  output logic                             nonzero_o
`ifdef VR_VC_CREDIT_CHECK_EN
  ,
  output logic                             overflow_o
`endif
);

  localparam int CW = credit_w(CREDIT_NUM);
  localparam logic [CW-1:0] MAX = CW'(CREDIT_NUM);

  logic [CW-1:0] cnt_q, cnt_d;

  // A simultaneous spend and return cancel out; both ends clamp instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != MAX) cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= MAX;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign nonzero_o = (cnt_q != '0);

`ifdef VR_VC_CREDIT_CHECK_EN
  assign overflow_o = inc_i && !dec_i && (cnt_q == MAX);
`endif

endmodule

// File: rtl/vr_vc_converter.sv
// Valid/ready slave to valid/credit master bridge with a local credit mirror.
// Optional VR_VC_CREDIT_CHECK_EN adds a sticky err_o and an overflow assertion.
module vr_vc_converter
  import vr_vc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_credit_i
`ifdef VR_VC_CREDIT_CHECK_EN
  ,
  output logic                  err_o
`endif
);

  localparam int CW = credit_w(CREDIT_NUM);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  accept;
  logic                  cnt_nonzero;
  logic [CW-1:0]         credit_cnt;
`ifdef VR_VC_CREDIT_CHECK_EN
  logic                  credit_ovf;
  logic                  err_q, err_d;
`endif

  vr_vc_credit_cnt #(
    .CREDIT_NUM (CREDIT_NUM)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .dec_i      (accept),
    .inc_i      (m_credit_i),
    .cnt_o      (credit_cnt),
    .nonzero_o  (cnt_nonzero)
`ifdef VR_VC_CREDIT_CHECK_EN
    ,
    .overflow_o (credit_ovf)
`endif
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:   state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      default: state_d = RESET;
    endcase
  end

  // Ready is built from registers only, so upstream sees no path from valid or credit.
  assign s_ready_o = (state_q == ACTIVE) && cnt_nonzero;
  assign accept    = s_valid_i && s_ready_o;

  always_comb begin
    valid_d = accept;
    data_d  = accept ? s_data_i : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

`ifdef VR_VC_CREDIT_CHECK_EN
  assign err_d = err_q | credit_ovf;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;

  a_no_credit_overflow: assert property (@(posedge clk) disable iff (rst) !credit_ovf);
`endif

endmodule

// File: tb/tb_vr_vc_converter.sv
// Bench for vr_vc_converter: directed scenarios followed by random traffic
// compared cycle by cycle against a credit-accounting reference model.
module tb_vr_vc_converter;

  localparam int DW = 8;
  localparam int CN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_credit_i = 1'b0;
`ifdef VR_VC_CREDIT_CHECK_EN
  logic          err_o;
`endif

  always #5 clk = ~clk;

  vr_vc_converter #(
    .DATA_WIDTH (DW),
    .CREDIT_NUM (CN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data_i   (s_data_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_credit_i (m_credit_i)
`ifdef VR_VC_CREDIT_CHECK_EN
    ,
    .err_o      (err_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: credits held, whether out of reset, last emitted beat, error flag.
  int            mdl_credits = CN;
  bit            mdl_active  = 1'b0;
  bit            mdl_valid   = 1'b0;
  logic [DW-1:0] mdl_data    = '0;
  bit            mdl_err     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mdl_ready();
    return mdl_active && (mdl_credits > 0);
  endfunction

  // One clock: apply inputs, let the edge happen, advance the model, compare everything.
  task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d, input bit c);
    bit acc;
    rst        = r;
    s_valid_i  = v;
    s_data_i   = d;
    m_credit_i = c;
    acc = v && mdl_ready();
    @(posedge clk);
    #1;
    if (r) begin
      mdl_credits = CN;
      mdl_active  = 1'b0;
      mdl_valid   = 1'b0;
      mdl_data    = '0;
      mdl_err     = 1'b0;
    end else begin
      if (c && !acc && mdl_credits == CN) mdl_err = 1'b1;
      mdl_valid = acc;
      if (acc) mdl_data = d;
      mdl_credits = mdl_credits - int'(acc) + int'(c);
      if (mdl_credits > CN) mdl_credits = CN;
      if (mdl_credits < 0)  mdl_credits = 0;
      mdl_active = 1'b1;
    end
    check("s_ready", 32'(s_ready_o), 32'(mdl_ready()));
    check("m_valid", 32'(m_valid_o), 32'(mdl_valid));
    check("m_data",  32'(m_data_o),  32'(mdl_data));
    check("credit_cnt", 32'(dut.credit_cnt), 32'(mdl_credits));
`ifdef VR_VC_CREDIT_CHECK_EN
    check("err", 32'(err_o), 32'(mdl_err));
`endif
  endtask

  initial begin
    // Reset and release
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    check("ready_after_release", 32'(s_ready_o), 32'd1);
    check("cnt_after_release", 32'(dut.credit_cnt), 32'd2);

    // Single beat
    cycle(0, 1, 8'hEE, 0);
    check("single_data", 32'(m_data_o), 32'hEE);
    check("single_cnt", 32'(dut.credit_cnt), 32'd1);
    cycle(0, 0, 8'h00, 0);
    check("single_pulse_end", 32'(m_valid_o), 32'd0);

    // Exhaust credits, hold 8'h22 upstream, then release it with one credit
    cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'hFF, 0);
    cycle(0, 1, 8'h11, 0);
    check("exhaust_ready", 32'(s_ready_o), 32'd0);
    cycle(0, 1, 8'h22, 0);
    check("held_no_valid", 32'(m_valid_o), 32'd0);
    cycle(0, 1, 8'h22, 1);
    cycle(0, 1, 8'h22, 0);
    check("late_beat", 32'(m_data_o), 32'h22);

    // Simultaneous accept and credit return at credit_cnt==1
    cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'h33, 1);
    check("simul_cnt", 32'(dut.credit_cnt), 32'd1);

    // Overflow: return a credit while already full
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    check("ovf_cnt", 32'(dut.credit_cnt), 32'd2);
    cycle(0, 0, 8'h00, 0);

    // Reset mid-stream with no credits and a pending beat
    cycle(0, 1, 8'h40, 0);
    cycle(0, 1, 8'h41, 0);
    cycle(0, 1, 8'h44, 0);
    cycle(1, 1, 8'h44, 0);
    check("rst_mid_valid", 32'(m_valid_o), 32'd0);
    cycle(0, 0, 8'h00, 0);
    check("rst_mid_cnt", 32'(dut.credit_cnt), 32'd2);

    // Random traffic; credits are only returned when the receiver could have one to return
    for (int i = 0; i < 3000; i++) begin
      bit r, v, c, acc;
      logic [DW-1:0] d;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = DW'($urandom);
      acc = v && mdl_ready();
      c   = ($urandom_range(0, 2) != 0) && ((mdl_credits < CN) || acc);
      cycle(r, v, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
